// File: rtl/cam_frame_buf_sched_if.sv
// Control/status bundle between the soft-core side (master) and the
// frame buffer scheduler (slave): event pulses in, buffer indices and
// statistics out.
interface cam_frame_buf_sched_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
);
    logic             enable;
    logic             wr_frame_start;
    logic             wr_frame_done;
    logic             rd_claim;
    logic             rd_release;
    logic [IDX_W-1:0] wr_index;
    logic             wr_active;
    logic [IDX_W-1:0] rd_index;
    logic             rd_active;
    logic             rd_grant;
    logic             rd_miss;
    logic             frame_ready;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output enable, wr_frame_start, wr_frame_done, rd_claim, rd_release,
        input  wr_index, wr_active, rd_index, rd_active, rd_grant, rd_miss,
        input  frame_ready, frame_cnt, drop_cnt
    );

    modport slave (
        input  enable, wr_frame_start, wr_frame_done, rd_claim, rd_release,
        output wr_index, wr_active, rd_index, rd_active, rd_grant, rd_miss,
        output frame_ready, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/cam_frame_buf_sched.sv
// Camera frame buffer scheduler: hands DDR frame buffers to one writer
// and one reader so the writer never touches the reader's buffer and the
// reader always gets the newest complete frame. Each buffer carries its
// own FREE/WRITING/READY/READING state; same-cycle events are applied in
// the order done -> claim -> release -> start.
module cam_frame_buf_sched #(
    parameter int NUM_BUFS = 3,
    parameter int IDX_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                  aclk,
    input  logic                  rst_n,
    cam_frame_buf_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_WRITING = 2'd1,
        BUF_READY   = 2'd2,
        BUF_READING = 2'd3
    } buf_state_e;

    buf_state_e       buf_q [NUM_BUFS];
    buf_state_e       buf_d [NUM_BUFS];

    logic [IDX_W-1:0] wr_index_q, wr_index_d;
    logic             wr_active_q, wr_active_d;
    logic [IDX_W-1:0] rd_index_q, rd_index_d;
    logic             rd_active_q, rd_active_d;
    logic             rd_grant_q, rd_grant_d;
    logic             rd_miss_q, rd_miss_d;
    logic             frame_ready_q, frame_ready_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             frame_inc;
    logic [1:0]       drop_inc;
    logic             claim_found;
    logic [IDX_W-1:0] claim_idx;
    logic             free_found;
    logic [IDX_W-1:0] sel_idx;

    // Apply this cycle's events in priority order to produce the next buffer map and outputs
    always_comb begin
        buf_d         = buf_q;
        wr_index_d    = wr_index_q;
        wr_active_d   = wr_active_q;
        rd_index_d    = rd_index_q;
        rd_active_d   = rd_active_q;
        rd_grant_d    = 1'b0;
        rd_miss_d     = 1'b0;
        frame_ready_d = 1'b0;
        frame_inc     = 1'b0;
        drop_inc      = 2'd0;
        claim_found   = 1'b0;
        claim_idx     = '0;
        free_found    = 1'b0;
        sel_idx       = '0;

        if (!bus.enable) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                buf_d[i] = BUF_FREE;
            end
            wr_index_d  = '0;
            wr_active_d = 1'b0;
            rd_index_d  = '0;
            rd_active_d = 1'b0;
        end else begin
            if (bus.wr_frame_done && wr_active_d) begin
                for (int i = 0; i < NUM_BUFS; i++) begin
                    if (buf_d[i] == BUF_READY) begin
                        buf_d[i] = BUF_FREE;
                        drop_inc = drop_inc + 2'd1;
                    end
                end
                for (int i = 0; i < NUM_BUFS; i++) begin
                    if (IDX_W'(i) == wr_index_d) begin
                        buf_d[i] = BUF_READY;
                    end
                end
                frame_inc   = 1'b1;
                wr_active_d = 1'b0;
            end

            if (bus.rd_claim && !rd_active_d) begin
                for (int i = 0; i < NUM_BUFS; i++) begin
                    if (buf_d[i] == BUF_READY) begin
                        claim_found = 1'b1;
                        claim_idx   = IDX_W'(i);
                    end
                end
                if (claim_found) begin
                    for (int i = 0; i < NUM_BUFS; i++) begin
                        if (IDX_W'(i) == claim_idx) begin
                            buf_d[i] = BUF_READING;
                        end
                    end
                    rd_index_d  = claim_idx;
                    rd_active_d = 1'b1;
                    rd_grant_d  = 1'b1;
                end else begin
                    rd_miss_d = 1'b1;
                end
            end

            if (bus.rd_release && rd_active_d) begin
                for (int i = 0; i < NUM_BUFS; i++) begin
                    if (IDX_W'(i) == rd_index_d) begin
                        buf_d[i] = BUF_FREE;
                    end
                end
                rd_active_d = 1'b0;
            end

            if (bus.wr_frame_start) begin
                // A start without a done abandons the half-written frame
                if (wr_active_d) begin
                    for (int i = 0; i < NUM_BUFS; i++) begin
                        if (IDX_W'(i) == wr_index_d) begin
                            buf_d[i] = BUF_FREE;
                        end
                    end
                    drop_inc = drop_inc + 2'd1;
                end
                for (int i = NUM_BUFS - 1; i >= 0; i--) begin
                    if (buf_d[i] == BUF_FREE) begin
                        free_found = 1'b1;
                        sel_idx    = IDX_W'(i);
                    end
                end
                // No FREE buffer left: overwrite the unread READY frame
                if (!free_found) begin
                    for (int i = 0; i < NUM_BUFS; i++) begin
                        if (buf_d[i] == BUF_READY) begin
                            sel_idx = IDX_W'(i);
                        end
                    end
                    drop_inc = drop_inc + 2'd1;
                end
                for (int i = 0; i < NUM_BUFS; i++) begin
                    if (IDX_W'(i) == sel_idx) begin
                        buf_d[i] = BUF_WRITING;
                    end
                end
                wr_index_d  = sel_idx;
                wr_active_d = 1'b1;
            end
        end

        for (int i = 0; i < NUM_BUFS; i++) begin
            if (buf_d[i] == BUF_READY) begin
                frame_ready_d = 1'b1;
            end
        end

        frame_cnt_d = frame_cnt_q + CNT_W'(frame_inc);
        drop_cnt_d  = drop_cnt_q + CNT_W'(drop_inc);
    end

    // Register buffer map, indices, pulses and statistics
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                buf_q[i] <= BUF_FREE;
            end
            wr_index_q    <= '0;
            wr_active_q   <= 1'b0;
            rd_index_q    <= '0;
            rd_active_q   <= 1'b0;
            rd_grant_q    <= 1'b0;
            rd_miss_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
        end else begin
            buf_q         <= buf_d;
            wr_index_q    <= wr_index_d;
            wr_active_q   <= wr_active_d;
            rd_index_q    <= rd_index_d;
            rd_active_q   <= rd_active_d;
            rd_grant_q    <= rd_grant_d;
            rd_miss_q     <= rd_miss_d;
            frame_ready_q <= frame_ready_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign bus.wr_index    = wr_index_q;
    assign bus.wr_active   = wr_active_q;
    assign bus.rd_index    = rd_index_q;
    assign bus.rd_active   = rd_active_q;
    assign bus.rd_grant    = rd_grant_q;
    assign bus.rd_miss     = rd_miss_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_cam_frame_buf_sched.sv
// Bench for the camera frame buffer scheduler: a table of single-cycle
// event vectors with expected registered outputs, queued when driven and
// compared one cycle later, then hand-written async reset and counter
// wrap sequences.
module tb_cam_frame_buf_sched;

    localparam int NUM_BUFS = 3;
    localparam int IDX_W    = 3;
    localparam int CNT_W    = 16;
    localparam int NVEC     = 25;

    typedef struct packed {
        logic [IDX_W-1:0] wr_index;
        logic             wr_active;
        logic [IDX_W-1:0] rd_index;
        logic             rd_active;
        logic             rd_grant;
        logic             rd_miss;
        logic             frame_ready;
        logic [CNT_W-1:0] frame_cnt;
        logic [CNT_W-1:0] drop_cnt;
    } exp_t;

    typedef struct packed {
        logic en;
        logic start;
        logic done;
        logic claim;
        logic rel;
        exp_t exp;
    } vec_t;

    logic aclk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb_q[$];
    vec_t vecs[NVEC];

    cam_frame_buf_sched_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    cam_frame_buf_sched #(
        .NUM_BUFS(NUM_BUFS),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) dut (
        .aclk (aclk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Free-running 10-unit clock
    always #5 aclk = ~aclk;

    function automatic exp_t mk(input int wi, input int wa, input int ri, input int ra,
                                input int g, input int m, input int r,
                                input int f, input int d);
        exp_t e;
        e.wr_index    = IDX_W'(wi);
        e.wr_active   = 1'(wa);
        e.rd_index    = IDX_W'(ri);
        e.rd_active   = 1'(ra);
        e.rd_grant    = 1'(g);
        e.rd_miss     = 1'(m);
        e.frame_ready = 1'(r);
        e.frame_cnt   = CNT_W'(f);
        e.drop_cnt    = CNT_W'(d);
        return e;
    endfunction

    function automatic vec_t mv(input logic en, input logic st, input logic dn,
                                input logic cl, input logic rl, input exp_t e);
        vec_t v;
        v.en    = en;
        v.start = st;
        v.done  = dn;
        v.claim = cl;
        v.rel   = rl;
        v.exp   = e;
        return v;
    endfunction

    // Drive one cycle of events and queue the outputs they should produce
    task automatic applyStimulus(input vec_t v);
        bus.enable         = v.en;
        bus.wr_frame_start = v.start;
        bus.wr_frame_done  = v.done;
        bus.rd_claim       = v.claim;
        bus.rd_release     = v.rel;
        sb_q.push_back(v.exp);
    endtask

    // Pop the oldest expectation and compare it with the current outputs
    task automatic checkOutput(input string name);
        exp_t e;
        exp_t a;
        a.wr_index    = bus.wr_index;
        a.wr_active   = bus.wr_active;
        a.rd_index    = bus.rd_index;
        a.rd_active   = bus.rd_active;
        a.rd_grant    = bus.rd_grant;
        a.rd_miss     = bus.rd_miss;
        a.frame_ready = bus.frame_ready;
        a.frame_cnt   = bus.frame_cnt;
        a.drop_cnt    = bus.drop_cnt;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL %s: no expectation queued", name);
        end else begin
            e = sb_q.pop_front();
            if (a !== e) begin
                mismatched++;
                $display("[TB] FAIL %s: got wr=%0d/%0b rd=%0d/%0b g=%0b m=%0b rdy=%0b fc=%0d dc=%0d, want wr=%0d/%0b rd=%0d/%0b g=%0b m=%0b rdy=%0b fc=%0d dc=%0d",
                         name, a.wr_index, a.wr_active, a.rd_index, a.rd_active, a.rd_grant,
                         a.rd_miss, a.frame_ready, a.frame_cnt, a.drop_cnt,
                         e.wr_index, e.wr_active, e.rd_index, e.rd_active, e.rd_grant,
                         e.rd_miss, e.frame_ready, e.frame_cnt, e.drop_cnt);
            end
        end
    endtask

    // Writer and reader must never share a buffer while both are active
    always @(negedge aclk) begin
        if (rst_n === 1'b1 && bus.wr_active === 1'b1 && bus.rd_active === 1'b1) begin
            compared++;
            if (bus.wr_index === bus.rd_index) begin
                mismatched++;
                $display("[TB] FAIL overlap: wr_index=%0d rd_index=%0d, want different",
                         bus.wr_index, bus.rd_index);
            end
        end
    end

    initial begin
        vecs[0]  = mv(1,0,0,0,0, mk(0,0,0,0,0,0,0,0,0));
        vecs[1]  = mv(1,1,0,0,0, mk(0,1,0,0,0,0,0,0,0));
        vecs[2]  = mv(1,0,1,0,0, mk(0,0,0,0,0,0,1,1,0));
        vecs[3]  = mv(1,0,0,1,0, mk(0,0,0,1,1,0,0,1,0));
        vecs[4]  = mv(1,1,0,0,0, mk(1,1,0,1,0,0,0,1,0));
        vecs[5]  = mv(1,0,1,0,0, mk(1,0,0,1,0,0,1,2,0));
        vecs[6]  = mv(1,1,0,0,0, mk(2,1,0,1,0,0,1,2,0));
        vecs[7]  = mv(1,0,1,0,0, mk(2,0,0,1,0,0,1,3,1));
        vecs[8]  = mv(1,0,0,1,0, mk(2,0,0,1,0,0,1,3,1));
        vecs[9]  = mv(1,0,0,0,1, mk(2,0,0,0,0,0,1,3,1));
        vecs[10] = mv(1,0,0,1,0, mk(2,0,2,1,1,0,0,3,1));
        vecs[11] = mv(1,0,0,0,1, mk(2,0,2,0,0,0,0,3,1));
        vecs[12] = mv(1,0,0,1,0, mk(2,0,2,0,0,1,0,3,1));
        vecs[13] = mv(1,0,0,0,0, mk(2,0,2,0,0,0,0,3,1));
        vecs[14] = mv(1,1,0,0,0, mk(0,1,2,0,0,0,0,3,1));
        vecs[15] = mv(1,1,1,1,0, mk(1,1,0,1,1,0,0,4,1));
        vecs[16] = mv(1,1,0,0,0, mk(1,1,0,1,0,0,0,4,2));
        vecs[17] = mv(1,0,1,0,0, mk(1,0,0,1,0,0,1,5,2));
        vecs[18] = mv(1,0,0,0,1, mk(1,0,0,0,0,0,1,5,2));
        vecs[19] = mv(1,1,0,0,0, mk(0,1,0,0,0,0,1,5,2));
        vecs[20] = mv(1,1,1,0,0, mk(1,1,0,0,0,0,1,6,3));
        vecs[21] = mv(1,0,0,1,0, mk(1,1,0,1,1,0,0,6,3));
        vecs[22] = mv(0,1,1,1,1, mk(0,0,0,0,0,0,0,6,3));
        vecs[23] = mv(1,0,0,0,0, mk(0,0,0,0,0,0,0,6,3));
        vecs[24] = mv(1,0,0,1,0, mk(0,0,0,0,0,1,0,6,3));

        rst_n              = 1'b0;
        bus.enable         = 1'b0;
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;
        bus.rd_claim       = 1'b0;
        bus.rd_release     = 1'b0;

        repeat (2) @(negedge aclk);
        sb_q.push_back(mk(0,0,0,0,0,0,0,0,0));
        checkOutput("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(negedge aclk);
            checkOutput($sformatf("vec%0d", i));
        end

        // Start a frame, then pull reset mid-cycle and look before the next edge
        applyStimulus(mv(1,1,0,0,0, mk(0,1,0,0,0,0,0,6,3)));
        @(negedge aclk);
        checkOutput("pre_reset_start");
        applyStimulus(mv(1,0,0,0,0, mk(0,0,0,0,0,0,0,0,0)));
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset");
        @(negedge aclk);
        rst_n = 1'b1;

        // 65537 back-to-back frames: frame counter wraps to 1, drops wrap to 0
        bus.enable         = 1'b1;
        bus.wr_frame_start = 1'b1;
        bus.wr_frame_done  = 1'b0;
        @(negedge aclk);
        bus.wr_frame_done = 1'b1;
        repeat (65536) @(negedge aclk);
        applyStimulus(mv(1,0,1,0,0, mk(0,0,0,0,0,0,1,1,0)));
        @(negedge aclk);
        checkOutput("frame_cnt_wrap");
        bus.wr_frame_done = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
